// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the five-stage core.
// Produces operand forwarding selects, stage stall/flush controls, and
// tracks data-memory wait states with a timeout and a stall-cycle counter.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             pcsrcM,
  input  logic             memenM,
  input  logic             mem_ready,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  // wcnt holds the number of consecutive not-ready cycles already completed,
  // so the cycle being evaluated is the (wcnt+1)-th one.
  localparam logic [15:0] TIMEOUT_M1 = 16'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic memstall;
  logic lwstall;
  logic mem_wait_now;

  // The M-stage load flag is part of the pipelined control bundle but no
  // hazard decision depends on it.
  logic unused_memtoregM;
  assign unused_memtoregM = memtoregM;

  // Select the forwarding source for one ALU operand; M beats W, r0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       rw_m,
    input logic [4:0] wr_m,
    input logic       rw_w,
    input logic [4:0] wr_w
  );
    if (rw_m && (wr_m != 5'd0) && (wr_m == src)) begin
      return 2'b10;
    end else if (rw_w && (wr_w != 5'd0) && (wr_w == src)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Operand forwarding for both Execute-stage sources.
  always_comb begin
    forwardAE = fwd_sel(rsE, regwriteM, writeregM, regwriteW, writeregW);
    forwardBE = fwd_sel(rtE, regwriteM, writeregM, regwriteW, writeregW);
  end

  // Hazard conditions and the prioritised stall/flush outputs.
  always_comb begin
    mem_wait_now = memenM & ~mem_ready;
    memstall     = mem_wait_now | (state_q == ERR);
    lwstall      = memtoregE & regwriteE & (writeregE != 5'd0) &
                   ((writeregE == rsD) | (writeregE == rtD));
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (memstall) begin
      // Whole front of the pipe freezes; branch and load-use are re-seen later.
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (pcsrcM) begin
      // Taken branch squashes the load-dependent instruction too.
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (lwstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  // Next-state logic for the memory-wait tracker and the stall counter.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      IDLE, WAIT: begin
        if (!mem_wait_now) begin
          // Access finished, never started, or was abandoned.
          state_d = IDLE;
          wcnt_d  = 16'd0;
        end else if (wcnt_q == TIMEOUT_M1) begin
          state_d   = ERR;
          mem_err_d = 1'b1;
        end else begin
          state_d = WAIT;
          wcnt_d  = wcnt_q + 16'd1;
        end
      end
      ERR: begin
        mem_err_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = 16'd0;
      end
    endcase
    if (stallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wcnt_q      <= 16'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a model.
module tb_hazard_unit;

  localparam int T      = 4;
  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [4:0]    rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic          regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic          pcsrcM, memenM, mem_ready;
  logic [1:0]    forwardAE, forwardBE;
  logic          stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic          mem_err;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: consecutive not-ready run, sticky error, stall count.
  int m_run = 0;
  bit m_err = 1'b0;
  int m_cnt = 0;

  hazard_unit #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst_n),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .pcsrcM(pcsrcM), .memenM(memenM), .mem_ready(mem_ready),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (regwriteM && writeregM != 0 && writeregM == src) return 2'b10;
    if (regwriteW && writeregW != 0 && writeregW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_memstall();
    return m_err || (memenM && !mem_ready);
  endfunction

  function automatic bit m_lw();
    return memtoregE && regwriteE && writeregE != 0 &&
           (writeregE == rsD || writeregE == rtD);
  endfunction

  // {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
  function automatic logic [6:0] m_ctl();
    if (m_memstall()) return 7'b1111_001;
    if (pcsrcM)       return 7'b0000_110;
    if (m_lw())       return 7'b1100_010;
    return 7'b0000_000;
  endfunction

  // Model advance on each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0;
      m_err <= 1'b0;
      m_cnt <= 0;
    end else begin
      if (m_ctl() & 7'b1000_000) begin
        if (m_cnt < CNTMAX) m_cnt <= m_cnt + 1;
      end
      if (!m_err) begin
        if (memenM && !mem_ready) begin
          m_run <= m_run + 1;
          if (m_run + 1 >= T) m_err <= 1'b1;
        end else begin
          m_run <= 0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("fwdA", {30'd0, forwardAE}, {30'd0, m_fwd(rsE)});
    chk("fwdB", {30'd0, forwardBE}, {30'd0, m_fwd(rtE)});
    chk("ctl", {25'd0, stallF, stallD, stallE, stallM, flushD, flushE, flushW},
        {25'd0, m_ctl()});
    chk("mem_err", {31'd0, mem_err}, {31'd0, m_err});
    chk("stall_cnt", {28'd0, stall_cnt}, m_cnt);
  end

  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0;
    pcsrcM = 0; memenM = 0; mem_ready = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #3;
    chk("rst_mem_err", {31'd0, mem_err}, 0);
    chk("rst_stall_cnt", {28'd0, stall_cnt}, 0);
    step();
    rst_n = 1'b1;

    // Forwarding priority
    rsE = 5; rtE = 5; regwriteM = 1; writeregM = 5; regwriteW = 1; writeregW = 5;
    #1;
    chk("fwd_m_pri_A", {30'd0, forwardAE}, 2);
    chk("fwd_m_pri_B", {30'd0, forwardBE}, 2);
    regwriteM = 0;
    #1;
    chk("fwd_w_A", {30'd0, forwardAE}, 1);
    rsE = 0; writeregM = 0; writeregW = 0; regwriteM = 1;
    #1;
    chk("fwd_r0_A", {30'd0, forwardAE}, 0);

    // Load-use stall
    step();
    clear_inputs();
    memtoregE = 1; regwriteE = 1; writeregE = 8; rtD = 8;
    #1;
    chk("lw_stallF", {31'd0, stallF}, 1);
    chk("lw_stallD", {31'd0, stallD}, 1);
    chk("lw_flushE", {31'd0, flushE}, 1);
    chk("lw_stallE", {31'd0, stallE}, 0);
    step();
    clear_inputs();
    memtoregE = 1; regwriteE = 1; writeregE = 0; rtD = 0;
    #1;
    chk("lw_cnt1", {28'd0, stall_cnt}, 1);
    chk("lw_r0_nostall", {31'd0, stallF}, 0);

    // Branch beats load-use
    step();
    clear_inputs();
    memtoregE = 1; regwriteE = 1; writeregE = 8; rtD = 8; pcsrcM = 1;
    #1;
    chk("br_flushD", {31'd0, flushD}, 1);
    chk("br_flushE", {31'd0, flushE}, 1);
    chk("br_stallF", {31'd0, stallF}, 0);

    // Memory wait of 3 cycles with a coincident taken branch
    step();
    clear_inputs();
    memenM = 1; mem_ready = 0; pcsrcM = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_stalls", {28'd0, stallF, stallD, stallE, stallM}, 4'hf);
      chk("mw_flushW", {31'd0, flushW}, 1);
      chk("mw_noflushD", {31'd0, flushD}, 0);
      step();
    end
    mem_ready = 1;
    #1;
    chk("mw_done_stallF", {31'd0, stallF}, 0);
    chk("mw_done_flushD", {31'd0, flushD}, 1);
    step();
    clear_inputs();
    #1;
    chk("mw_cnt", {28'd0, stall_cnt}, 4);  // one load-use cycle + three wait cycles
    chk("mw_no_err", {31'd0, mem_err}, 0);

    // Timeout after 4 not-ready cycles, then saturation while in error
    step();
    memenM = 1; mem_ready = 0;
    step(); step(); step();
    #1;
    chk("to_not_yet", {31'd0, mem_err}, 0);
    step();
    chk("to_err", {31'd0, mem_err}, 1);
    memenM = 0;
    #1;
    chk("to_hold_stallF", {31'd0, stallF}, 1);
    chk("to_hold_stallM", {31'd0, stallM}, 1);
    repeat (20) step();
    chk("sat_cnt", {28'd0, stall_cnt}, 15);
    step();
    chk("sat_hold", {28'd0, stall_cnt}, 15);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_err", {31'd0, mem_err}, 0);
    chk("arst_cnt", {28'd0, stall_cnt}, 0);
    chk("arst_stallF", {31'd0, stallF}, 0);
    step();
    rst_n = 1'b1;

    // Randomized traffic checked by the per-cycle compare process
    for (int n = 0; n < 3000; n++) begin
      step();
      rst_n     = ($urandom_range(63) != 0);
      rsD       = 5'($urandom_range(3));
      rtD       = 5'($urandom_range(3));
      rsE       = 5'($urandom_range(3));
      rtE       = 5'($urandom_range(3));
      writeregE = 5'($urandom_range(3));
      writeregM = 5'($urandom_range(3));
      writeregW = 5'($urandom_range(3));
      regwriteE = 1'($urandom);
      regwriteM = 1'($urandom);
      regwriteW = 1'($urandom);
      memtoregE = 1'($urandom);
      memtoregM = 1'($urandom);
      pcsrcM    = ($urandom_range(3) == 0);
      memenM    = 1'($urandom);
      mem_ready = 1'($urandom);
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
